// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the SOIN-RV RV32I core: sequences fetch/decode/execute/memory/write-back.
// Optional JAL support is compiled in when MC_JAL_EN is defined; otherwise opcode 1101111 traps.
module multicycle_control (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [6:0] i_Opcode,
  input  logic       i_MemReady,
  input  logic       i_Zero,
  output logic       o_MemReq,
  output logic       o_MemWrite,
  output logic       o_IorD,
  output logic       o_IRWrite,
  output logic       o_PCWrite,
  output logic       o_PCWriteCond,
  output logic [1:0] o_PCSource,
  output logic [1:0] o_ALUSrcA,
  output logic [1:0] o_ALUSrcB,
  output logic [1:0] o_ALUOp,
  output logic [2:0] o_ImmSel,
  output logic       o_RegWrite,
  output logic       o_MemToReg,
  output logic       o_IllegalInstr
);

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned STATE_W = 4;

  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_ALU_R  = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_ALU_I  = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
`ifdef MC_JAL_EN
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
`endif

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_TRAP      = 4'd11
  } state_t;

  state_t state_q;
  state_t state_d;

  // State register; reset lands in FETCH
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and state-decoded outputs; IR/PC strobes are held off while reset is asserted
  always_comb begin
    state_d        = state_q;
    o_MemReq       = 1'b0;
    o_MemWrite     = 1'b0;
    o_IorD         = 1'b0;
    o_IRWrite      = 1'b0;
    o_PCWrite      = 1'b0;
    o_PCWriteCond  = 1'b0;
    o_PCSource     = 2'b00;
    o_ALUSrcA      = 2'b00;
    o_ALUSrcB      = 2'b00;
    o_ALUOp        = 2'b00;
    o_ImmSel       = 3'b000;
    o_RegWrite     = 1'b0;
    o_MemToReg     = 1'b0;
    o_IllegalInstr = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        o_MemReq  = 1'b1;
        o_ALUSrcB = 2'b01;
        if (i_MemReady) begin
          o_IRWrite = i_rstn;
          o_PCWrite = i_rstn;
          state_d   = S_DECODE;
        end
      end

      S_DECODE: begin
        o_ALUSrcA = 2'b10;
        o_ALUSrcB = 2'b10;
        o_ImmSel  = 3'b010;
        case (i_Opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_ALU_R:          state_d = S_EXEC_R;
          OP_ALU_I:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
`ifdef MC_JAL_EN
          OP_JAL:            state_d = S_JAL;
`endif
          default:           state_d = S_TRAP;
        endcase
      end

      S_MEM_ADDR: begin
        o_ALUSrcA = 2'b01;
        o_ALUSrcB = 2'b10;
        if (i_Opcode == OP_STORE) begin
          o_ImmSel = 3'b001;
          state_d  = S_MEM_WRITE;
        end else begin
          state_d  = S_MEM_READ;
        end
      end

      S_MEM_READ: begin
        o_MemReq = 1'b1;
        o_IorD   = 1'b1;
        if (i_MemReady) state_d = S_MEM_WB;
      end

      S_MEM_WB: begin
        o_RegWrite = 1'b1;
        o_MemToReg = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WRITE: begin
        o_MemReq   = 1'b1;
        o_MemWrite = 1'b1;
        o_IorD     = 1'b1;
        if (i_MemReady) state_d = S_FETCH;
      end

      S_EXEC_R: begin
        o_ALUSrcA = 2'b01;
        o_ALUOp   = 2'b10;
        state_d   = S_ALU_WB;
      end

      S_EXEC_I: begin
        o_ALUSrcA = 2'b01;
        o_ALUSrcB = 2'b10;
        o_ALUOp   = 2'b10;
        state_d   = S_ALU_WB;
      end

      S_ALU_WB: begin
        o_RegWrite = 1'b1;
        state_d    = S_FETCH;
      end

      // BEQ only: funct3 is not decoded
      S_BRANCH: begin
        o_ALUSrcA     = 2'b01;
        o_ALUOp       = 2'b01;
        o_PCSource    = 2'b01;
        o_PCWriteCond = 1'b1;
        o_PCWrite     = i_Zero;
        state_d       = S_FETCH;
      end

`ifdef MC_JAL_EN
      S_JAL: begin
        o_ImmSel   = 3'b011;
        o_ALUSrcA  = 2'b10;
        o_ALUSrcB  = 2'b10;
        o_PCWrite  = 1'b1;
        o_RegWrite = 1'b1;
        state_d    = S_FETCH;
      end
`endif

      S_TRAP: begin
        o_IllegalInstr = 1'b1;
        state_d        = S_TRAP;
      end

      // Unreachable encodings are treated as a fault
      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

endmodule
